// File: rtl/uart_int_arb.sv
// UART interrupt source latches and 16550-style IIR priority arbiter.
// Optional macro UART_CTI_EN adds the RX character-timeout source (ID 3'b110).
module uart_int_arb #(
  parameter int FIFO_DEPTH    = 16,
  parameter int LVL_W         = 5,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic             apb_clk_in,
  input  logic             apb_rstn_in,
  input  logic             erbi_in,
  input  logic             etbei_in,
  input  logic             elsi_in,
  input  logic             edssi_in,
  input  logic             fifoen_in,
  input  logic [1:0]       rxfiftl_in,
  input  logic [LVL_W-1:0] rx_level_in,
  input  logic             rx_char_done_in,
  input  logic             rx_err_in,
  input  logic             thr_empty_in,
  input  logic             char_tick_in,
  input  logic [3:0]       msr_delta_in,
  input  logic             iir_read_in,
  input  logic             lsr_read_in,
  input  logic             rbr_read_in,
  input  logic             thr_write_in,
  input  logic             msr_read_in,
  output logic [2:0]       intid_out,
  output logic             ipend_out,
  output logic             irq_out
);

  logic             ls_q, ls_d, ms_q, ms_d, te_q, te_d;
  logic             thr_empty_dly_q, etbei_dly_q;
  logic [2:0]       intid_q, intid_d;
  logic             ipend_q, ipend_d, irq_q;
  logic [LVL_W-1:0] trig_s;
  logic             rda_s, ct_s, te_set_s, te_clr_s;

  // Trigger levels scale with the FIFO depth; 1/4/8/14 for the standard 16-byte FIFO.
  always_comb begin
    case (rxfiftl_in)
      2'd0:    trig_s = LVL_W'(1);
      2'd1:    trig_s = LVL_W'(FIFO_DEPTH / 4);
      2'd2:    trig_s = LVL_W'(FIFO_DEPTH / 2);
      2'd3:    trig_s = LVL_W'(FIFO_DEPTH - 2);
      default: trig_s = LVL_W'(1);
    endcase
  end

  assign rda_s    = fifoen_in ? (rx_level_in >= trig_s) : (rx_level_in != {LVL_W{1'b0}});
  assign te_set_s = (thr_empty_in & ~thr_empty_dly_q) | (etbei_in & ~etbei_dly_q & thr_empty_in);
  assign te_clr_s = thr_write_in | (iir_read_in & (intid_q == 3'b001) & ~ipend_q);

`ifdef UART_CTI_EN
  localparam logic [2:0] CT_MAX = 3'(TIMEOUT_CHARS);
  logic [2:0] ct_cnt_q, ct_cnt_d;

  // Idle-character counter: any RX activity or an empty FIFO restarts it.
  always_comb begin
    ct_cnt_d = ct_cnt_q;
    if (!fifoen_in || rx_char_done_in || rbr_read_in || (rx_level_in == {LVL_W{1'b0}})) begin
      ct_cnt_d = 3'd0;
    end else if (char_tick_in && (ct_cnt_q != CT_MAX)) begin
      ct_cnt_d = ct_cnt_q + 3'd1;
    end else begin
      ct_cnt_d = ct_cnt_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      ct_cnt_q <= 3'd0;
    end else begin
      ct_cnt_q <= ct_cnt_d;
    end
  end

  assign ct_s = fifoen_in & (ct_cnt_q == CT_MAX);
`else
  logic unused_cti_s;
  assign unused_cti_s = ^{char_tick_in, rx_char_done_in, rbr_read_in, 32'(TIMEOUT_CHARS)};
  assign ct_s         = 1'b0;
`endif

  // Pending latches; a set in the same cycle as a clear wins so no event is dropped.
  always_comb begin
    ls_d = ls_q;
    ms_d = ms_q;
    te_d = te_q;
    if (rx_err_in) ls_d = 1'b1;
    else if (lsr_read_in) ls_d = 1'b0;
    else ls_d = ls_q;
    if (|msr_delta_in) ms_d = 1'b1;
    else if (msr_read_in) ms_d = 1'b0;
    else ms_d = ms_q;
    if (te_set_s) te_d = 1'b1;
    else if (te_clr_s) te_d = 1'b0;
    else te_d = te_q;
  end

  // Priority encoder feeding the registered IIR outputs.
  always_comb begin
    intid_d = 3'b000;
    ipend_d = 1'b1;
    if (ls_q && elsi_in) begin
      intid_d = 3'b011; ipend_d = 1'b0;
    end else if (rda_s && erbi_in) begin
      intid_d = 3'b010; ipend_d = 1'b0;
    end else if (ct_s && erbi_in) begin
      intid_d = 3'b110; ipend_d = 1'b0;
    end else if (te_q && etbei_in) begin
      intid_d = 3'b001; ipend_d = 1'b0;
    end else if (ms_q && edssi_in) begin
      intid_d = 3'b000; ipend_d = 1'b0;
    end else begin
      intid_d = 3'b000; ipend_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      ls_q            <= 1'b0;
      ms_q            <= 1'b0;
      te_q            <= 1'b0;
      thr_empty_dly_q <= 1'b0;
      etbei_dly_q     <= 1'b0;
      intid_q         <= 3'b000;
      ipend_q         <= 1'b1;
      irq_q           <= 1'b0;
    end else begin
      ls_q            <= ls_d;
      ms_q            <= ms_d;
      te_q            <= te_d;
      thr_empty_dly_q <= thr_empty_in;
      etbei_dly_q     <= etbei_in;
      intid_q         <= intid_d;
      ipend_q         <= ipend_d;
      irq_q           <= ~ipend_d;
    end
  end

  assign intid_out = intid_q;
  assign ipend_out = ipend_q;
  assign irq_out   = irq_q;

endmodule

// File: tb/tb_uart_int_arb.sv
// Scoreboard bench for uart_int_arb; expectations are {intid, ipend, irq}.
module tb_uart_int_arb;

  localparam logic [4:0] NONE = 5'b000_1_0;
  localparam logic [4:0] LS   = 5'b011_0_1;
  localparam logic [4:0] RDA  = 5'b010_0_1;
  localparam logic [4:0] TE   = 5'b001_0_1;
  localparam logic [4:0] MS   = 5'b000_0_1;
`ifdef UART_CTI_EN
  localparam logic [4:0] CT   = 5'b110_0_1;
`else
  localparam logic [4:0] CT   = NONE;
`endif

  logic       clk = 1'b0;
  logic       rstn, erbi, etbei, elsi, edssi, fifoen;
  logic [1:0] rxfiftl;
  logic [4:0] level;
  logic       char_done, rx_err, thr_empty, tick;
  logic [3:0] msr_delta;
  logic       iir_read, lsr_read, rbr_read, thr_write, msr_read;
  logic [2:0] intid;
  logic       ipend, irq;

  logic [4:0] sb[$];
  logic [4:0] exp_v, got_v;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  uart_int_arb dut (
    .apb_clk_in(clk), .apb_rstn_in(rstn),
    .erbi_in(erbi), .etbei_in(etbei), .elsi_in(elsi), .edssi_in(edssi),
    .fifoen_in(fifoen), .rxfiftl_in(rxfiftl), .rx_level_in(level),
    .rx_char_done_in(char_done), .rx_err_in(rx_err), .thr_empty_in(thr_empty),
    .char_tick_in(tick), .msr_delta_in(msr_delta),
    .iir_read_in(iir_read), .lsr_read_in(lsr_read), .rbr_read_in(rbr_read),
    .thr_write_in(thr_write), .msr_read_in(msr_read),
    .intid_out(intid), .ipend_out(ipend), .irq_out(irq)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_state: got=%b exp=%b", got_v, exp_v); end
    elsi = 1'b1; rx_err = 1'b1; cyc(1); rx_err = 1'b0; cyc(1);
    sb.push_back(LS);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ls_before_reset: got=%b exp=%b", got_v, exp_v); end
    #3 rstn = 1'b0; #1;
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL async_reset: got=%b exp=%b", got_v, exp_v); end
    cyc(1); rstn = 1'b1; cyc(3);
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL post_reset_idle: got=%b exp=%b", got_v, exp_v); end
    elsi = 1'b0;
  endtask

  task automatic test_priority;
    elsi = 1'b1; erbi = 1'b1; etbei = 1'b1; thr_empty = 1'b1; cyc(1);
    sb.push_back(NONE); sb.push_back(TE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL te_latency: got=%b exp=%b", got_v, exp_v); end
    cyc(1);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL te_rise: got=%b exp=%b", got_v, exp_v); end
    rx_err = 1'b1; cyc(1); rx_err = 1'b0;
    sb.push_back(TE); sb.push_back(LS);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ls_latency: got=%b exp=%b", got_v, exp_v); end
    cyc(1);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ls_over_te: got=%b exp=%b", got_v, exp_v); end
    lsr_read = 1'b1; cyc(1); lsr_read = 1'b0; cyc(1);
    sb.push_back(TE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL lsr_read_clear: got=%b exp=%b", got_v, exp_v); end
    thr_write = 1'b1; cyc(1); thr_write = 1'b0; thr_empty = 1'b0; cyc(2);
    elsi = 1'b0; etbei = 1'b0;
  endtask

  task automatic test_fifo_trigger;
    fifoen = 1'b1; rxfiftl = 2'd2; erbi = 1'b1; level = 5'd7; cyc(1);
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL level7_below_trig: got=%b exp=%b", got_v, exp_v); end
    level = 5'd8;
    sb.push_back(NONE); sb.push_back(RDA);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rda_latency: got=%b exp=%b", got_v, exp_v); end
    cyc(1);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rda_trig8: got=%b exp=%b", got_v, exp_v); end
    rbr_read = 1'b1; level = 5'd7; cyc(1); rbr_read = 1'b0;
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rda_drop: got=%b exp=%b", got_v, exp_v); end
    level = 5'd8; erbi = 1'b0; cyc(1);
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL erbi_mask: got=%b exp=%b", got_v, exp_v); end
    erbi = 1'b1; cyc(1);
    sb.push_back(RDA);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL erbi_restore: got=%b exp=%b", got_v, exp_v); end
    fifoen = 1'b0; level = 5'd1; cyc(1);
    sb.push_back(RDA);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL nonfifo_rda: got=%b exp=%b", got_v, exp_v); end
    level = 5'd0; cyc(1);
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL nonfifo_empty: got=%b exp=%b", got_v, exp_v); end
  endtask

  task automatic test_timeout;
    fifoen = 1'b1; rxfiftl = 2'd3; level = 5'd3; erbi = 1'b1; cyc(2);
    for (int i = 1; i <= 4; i++) begin
      tick = 1'b1; cyc(1); tick = 1'b0;
      sb.push_back(NONE);
      exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL ct_before_tick%0d: got=%b exp=%b", i, got_v, exp_v); end
    end
    cyc(1);
    sb.push_back(CT);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ct_fire: got=%b exp=%b", got_v, exp_v); end
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    sb.push_back(CT);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ct_saturate: got=%b exp=%b", got_v, exp_v); end
    rbr_read = 1'b1; level = 5'd2; cyc(1); rbr_read = 1'b0; cyc(1);
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ct_rbr_clear: got=%b exp=%b", got_v, exp_v); end
    level = 5'd0; fifoen = 1'b0; erbi = 1'b0; cyc(1);
  endtask

  task automatic test_thre_clear;
    etbei = 1'b1; thr_empty = 1'b1; cyc(2);
    sb.push_back(TE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL thre_set: got=%b exp=%b", got_v, exp_v); end
    iir_read = 1'b1; cyc(1); iir_read = 1'b0; cyc(1);
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL iir_read_clear: got=%b exp=%b", got_v, exp_v); end
    etbei = 1'b0; cyc(1); etbei = 1'b1; cyc(2);
    sb.push_back(TE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL etbei_reenable: got=%b exp=%b", got_v, exp_v); end
    thr_write = 1'b1; cyc(1); thr_write = 1'b0; cyc(1);
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL thr_write_clear: got=%b exp=%b", got_v, exp_v); end
    etbei = 1'b0; thr_empty = 1'b0; cyc(1);
  endtask

  task automatic test_collision;
    edssi = 1'b1; msr_delta = 4'b0100; cyc(1); msr_delta = 4'b0000; cyc(1);
    sb.push_back(MS);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ms_set: got=%b exp=%b", got_v, exp_v); end
    msr_read = 1'b1; msr_delta = 4'b0001; cyc(1); msr_read = 1'b0; msr_delta = 4'b0000; cyc(1);
    sb.push_back(MS);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ms_collision: got=%b exp=%b", got_v, exp_v); end
    msr_read = 1'b1; cyc(1); msr_read = 1'b0; cyc(1);
    sb.push_back(NONE);
    exp_v = sb.pop_front(); got_v = {intid, ipend, irq}; checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ms_clear: got=%b exp=%b", got_v, exp_v); end
    edssi = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; erbi = 1'b0; etbei = 1'b0; elsi = 1'b0; edssi = 1'b0; fifoen = 1'b0;
    rxfiftl = 2'd0; level = 5'd0; char_done = 1'b0; rx_err = 1'b0; thr_empty = 1'b0;
    tick = 1'b0; msr_delta = 4'b0000; iir_read = 1'b0; lsr_read = 1'b0; rbr_read = 1'b0;
    thr_write = 1'b0; msr_read = 1'b0;
    cyc(2); rstn = 1'b1; cyc(1);
    test_reset;
    test_priority;
    test_fifo_trigger;
    test_timeout;
    test_thre_clear;
    test_collision;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_int_arb.md
Name: uart_int_arb

Overview:
Interrupt source controller and priority arbiter for the UART. It latches the line-status, receive-data, character-timeout, transmit-empty and modem-status interrupt sources and qualifies them with the IER enables. It arbitrates them into a single 16550-style IIR code (intid/ipend) that feeds the register block's intid_in/ipend_in, and drives the CPU interrupt line. It sits between the register block and the TX/RX datapaths.

Parameters:
FIFO_DEPTH, 16, RX FIFO depth in bytes.
LVL_W, 5, width of the RX FIFO level input; must hold FIFO_DEPTH.
TIMEOUT_CHARS, 4, character times of RX inactivity before a character timeout fires; range 1..7.

Ports:
apb_clk_in  in  1  APB clock
apb_rstn_in  in  1  async active-low reset
erbi_in  in  1  RX data / timeout interrupt enable
etbei_in  in  1  THR-empty interrupt enable
elsi_in  in  1  line-status interrupt enable
edssi_in  in  1  modem-status interrupt enable
fifoen_in  in  1  FIFO mode enable
rxfiftl_in  in  2  RX trigger select: 0=1, 1=4, 2=8, 3=14 bytes
rx_level_in  in  LVL_W  current RX FIFO byte count
rx_char_done_in  in  1  pulse, one character received into RX
rx_err_in  in  1  pulse: overrun, parity, framing or break detected
thr_empty_in  in  1  level: THR/TX FIFO empty
char_tick_in  in  1  pulse, one per character time from the baud generator
msr_delta_in  in  4  pulses: DCTS, DDSR, TERI, DDCD
iir_read_in  in  1  pulse, IIR read completed
lsr_read_in  in  1  pulse, LSR read completed
rbr_read_in  in  1  pulse, RBR/FIFO byte read
thr_write_in  in  1  pulse, THR written
msr_read_in  in  1  pulse, MSR read completed
intid_out  out  3  highest-priority pending interrupt ID
ipend_out  out  1  0 = interrupt pending, 1 = none
irq_out  out  1  interrupt request to the CPU, active high

Behaviour:
- Clock and reset: reset is apb_rstn_in, asynchronous, active-low; clock is apb_clk_in. All state is on the rising edge.
- Reset values: intid_out=3'b000, ipend_out=1, irq_out=0. All pending latches and the timeout counter are cleared.
- Line-status latch (LS): set by rx_err_in; cleared by lsr_read_in.
- Modem-status latch (MS): set by any bit of msr_delta_in; cleared by msr_read_in.
- THR-empty latch (TE) is set in either case:
  - on the cycle after thr_empty_in rises; or
  - on the cycle after etbei_in rises while thr_empty_in=1.
- TE is cleared in either case:
  - thr_write_in; or
  - iir_read_in while the registered intid_out=3'b001 and ipend_out=0.
- Set/clear collision: a set and a clear on the same latch in the same cycle resolves to set, so no event is lost.
- RX data available (RDA) is combinational, not latched:
  - FIFO mode: rx_level_in >= the trigger from rxfiftl_in.
  - Non-FIFO mode: rx_level_in != 0.
  - RDA clears naturally when reads lower the level.
- Character timeout (CT), FIFO mode only:
  - 3-bit counter increments on char_tick_in while rx_level_in != 0.
  - Counter resets to 0 on rx_char_done_in, on rbr_read_in, when rx_level_in==0, or when fifoen_in=0. Reset beats increment in the same cycle.
  - Counter saturates at TIMEOUT_CHARS. CT is asserted while count==TIMEOUT_CHARS.
- Arbitration, evaluated each cycle with each source ANDed with its enable, highest priority first:
  - 1: LS & elsi -> 3'b011
  - 2: RDA & erbi -> 3'b010
  - 3: CT & erbi -> 3'b110 (RDA wins if both are set)
  - 4: TE & etbei -> 3'b001
  - 5: MS & edssi -> 3'b000
  - None: intid=3'b000, ipend=1.
- Output timing: intid_out, ipend_out and irq_out are registered, one cycle after the source changes. irq_out equals ~ipend_out.
- Enable clear: clearing an enable drops that source from arbitration on the next cycle. The underlying latch is held, and the source re-asserts when the enable is set again (except TE, which follows the set rules above).
- fifoen_in=0: CT is forced off and its counter held at 0.

Optional Feature:
Macro UART_CTI_EN.
- Defined: character-timeout counter and ID 3'b110 are implemented as described above.
- Undefined: counter logic is absent, CT is constant 0, ID 3'b110 is never produced, char_tick_in is ignored, and the TIMEOUT_CHARS parameter is unused.

Test Plan:
- Reset mid-operation: with LS pending and elsi=1, drop apb_rstn_in -> outputs immediately read intid=000, ipend=1, irq=0; after release, no interrupt until a new event.
- Priority: elsi=erbi=etbei=1, thr_empty rises, then rx_err pulse -> intid=001, then 011 one cycle after the error; lsr_read -> 001.
- FIFO trigger: fifoen=1, rxfiftl=2, rx_level 7->8 -> intid=010, ipend=0 one cycle later; rbr_read dropping level to 7 -> ipend=1.
- Timeout (UART_CTI_EN): fifoen=1, rxfiftl=3, level=3, erbi=1, four char_tick pulses -> intid=110 after the fourth tick; rbr_read -> counter clears, ipend=1.
- THRE clear: etbei=1, thr_empty=1 -> intid=001; iir_read -> ipend=1; with thr_empty still 1, toggle etbei 0->1 -> intid=001 again.
- Collision: msr_read and msr_delta=4'b0001 in the same cycle with edssi=1 -> MS stays set, intid=000, ipend=0.
